// File: rtl/pea_fire_ctrl.sv
// PEA actor firing controller: SETUP/INSTR two-phase fire sequencing.
// Optional stall counter enabled by defining PEA_STALL_CNT_EN.
module pea_fire_ctrl #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024,
  parameter int arg_width   = 5,
  localparam int AW = (buffer_size > 1) ? $clog2(buffer_size) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW:0]          wr_addr_command,
  input  logic [AW:0]          rd_addr_command,
  input  logic [AW:0]          data_pop,
  input  logic [AW:0]          result_free_space,
  input  logic [AW:0]          status_free_space,
  input  logic [7:0]           mode,
  input  logic [arg_width-1:0] arg2,
  input  logic                 done,
  output logic                 enable,
  output logic                 phase,
  output logic                 illegal_mode
`ifdef PEA_STALL_CNT_EN
  ,
  output logic [31:0]          stall_count
`endif
);

  localparam int PW = AW + 1;
  localparam int MW = (PW > arg_width + 1) ? PW : arg_width + 1;
  localparam int CW = MW + 1 + 0 * word_size;

  typedef enum logic [1:0] {
    S_SETUP,
    S_SETUP_FIRE,
    S_INSTR,
    S_INSTR_FIRE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_run;
  logic                 r_enable;
  logic                 r_illegal;
  logic [7:0]           r_mode;
  logic [arg_width-1:0] r_arg2;

  logic                 w_en_nxt;
  logic                 w_ill_nxt;
  logic                 w_latch;
  logic [AW:0]          w_occ;
  logic                 w_has_cmd;
  logic                 w_mode_ok;
  logic                 w_cond;
  logic [CW-1:0]        w_dp;
  logic [CW-1:0]        w_rf;
  logic [CW-1:0]        w_sf;
  logic [CW-1:0]        w_arg;
  logic [CW-1:0]        w_arg1;
  logic [CW-1:0]        w_one;

  assign w_occ     = wr_addr_command - rd_addr_command;
  assign w_has_cmd = |w_occ;
  assign w_mode_ok = (r_mode <= 8'd3);

  assign w_dp   = {{(CW-PW){1'b0}}, data_pop};
  assign w_rf   = {{(CW-PW){1'b0}}, result_free_space};
  assign w_sf   = {{(CW-PW){1'b0}}, status_free_space};
  assign w_arg  = {{(CW-arg_width){1'b0}}, r_arg2};
  assign w_one  = {{(CW-1){1'b0}}, 1'b1};
  assign w_arg1 = w_arg + w_one;

  // Readiness test for the latched instruction
  always_comb begin
    w_cond = 1'b0;
    case (r_mode)
      8'd0: w_cond = (w_dp >= w_arg1) && (w_rf >= w_one)
                  && (w_sf >= w_one);
      8'd1: w_cond = (w_dp >= w_one) && (w_rf >= w_arg)
                  && (w_sf >= w_arg);
      8'd2: w_cond = (w_dp >= w_arg) && (w_rf >= w_arg)
                  && (w_sf >= w_arg);
      8'd3: w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  // Next state, latch strobe and registered-output targets
  always_comb begin
    w_next    = r_state;
    w_ill_nxt = 1'b0;
    w_latch   = 1'b0;
    if (r_run) begin
      unique case (r_state)
        S_SETUP: begin
          if (w_has_cmd) w_next = S_SETUP_FIRE;
        end
        S_SETUP_FIRE: begin
          if (done) begin
            w_latch = 1'b1;
            w_next  = S_INSTR;
          end
        end
        S_INSTR: begin
          if (!w_mode_ok) begin
            w_ill_nxt = 1'b1;
            w_next    = S_SETUP;
          end else if (w_cond) begin
            w_next = S_INSTR_FIRE;
          end
        end
        S_INSTR_FIRE: begin
          if (done) w_next = S_SETUP;
        end
      endcase
    end
    w_en_nxt = (w_next == S_SETUP_FIRE) ||
               (w_next == S_INSTR_FIRE);
  end

  // State, outputs and instruction latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_SETUP;
      r_run     <= 1'b0;
      r_enable  <= 1'b0;
      r_illegal <= 1'b0;
      r_mode    <= '0;
      r_arg2    <= '0;
    end else begin
      r_state   <= w_next;
      r_run     <= 1'b1;
      r_enable  <= w_en_nxt;
      r_illegal <= w_ill_nxt;
      if (w_latch) begin
        r_mode <= mode;
        r_arg2 <= arg2;
      end
    end
  end

  assign enable       = r_enable;
  assign illegal_mode = r_illegal;
  assign phase        = (r_state == S_INSTR) ||
                        (r_state == S_INSTR_FIRE);

`ifdef PEA_STALL_CNT_EN
  logic        w_stall;
  logic [31:0] r_stall;

  // A wait state with nothing to do counts as a stall
  always_comb begin
    w_stall = 1'b0;
    if (r_run) begin
      w_stall = ((r_state == S_SETUP) && !w_has_cmd) ||
                ((r_state == S_INSTR) && w_mode_ok && !w_cond);
    end
  end

  // Saturating stall counter, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (w_stall && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_count = r_stall;
`endif

endmodule
